vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator, the successor to the fixed 640x480 timing block in `tt_um_emern_vga`. It produces horizontal/vertical sync, pixel coordinates, a blanking flag and a command window for the GPU command path. Horizontal and vertical timing, sync polarity, counter width and pixel-clock division are all generics. It adds a run/hold enable and single-cycle line/frame start strobes. It sits between the system clock and the pixel pipeline; every downstream raster consumer keys off its outputs.

---
 rtl/vga_timing_gen.sv | 191 +++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// A pixel-clock divider gates a column/row counter pair. Every output is a
// register loaded from the next-state counters, so syncs, flags and strobes
// always describe the coordinates shown on row_counter/col_counter in the
// same cycle.
module vga_timing_gen #(
    parameter int CNT_W     = 10,
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit H_POL     = 1'b0,
    parameter bit V_POL     = 1'b0,
    parameter int PIX_DIV   = 1,
    parameter int CMD_LINES = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic             h_sync,
    output logic             v_sync,
    output logic [CNT_W-1:0] row_counter,
    output logic [CNT_W-1:0] col_counter,
    output logic             screen_inactive,
    output logic             cmd_en,
    output logic             line_start,
    output logic             frame_start
);

    // ------------------------------------------------------------------
    // Derived timing constants
    // ------------------------------------------------------------------
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Window bounds kept 32 bits wide so an end bound equal to the total
    // never overflows a narrow counter width.
    localparam logic [31:0] H_ACT_END = 32'(H_ACTIVE);
    localparam logic [31:0] HS_START  = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] HS_END    = 32'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [31:0] V_ACT_END = 32'(V_ACTIVE);
    localparam logic [31:0] VS_START  = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] VS_END    = 32'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [31:0] CMD_START = 32'(V_ACTIVE);
    localparam logic [31:0] CMD_END   = 32'(V_ACTIVE + CMD_LINES);

    localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_ZERO = '0;
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    generate
        if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
            V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_region
            $error("vga_timing_gen: every timing region must be at least 1 long");
        end
        if (CMD_LINES < 0 || CMD_LINES > V_FP + V_SYNC + V_BP) begin : g_bad_cmd
            $error("vga_timing_gen: CMD_LINES must fit inside the vertical blanking interval");
        end
        if (PIX_DIV < 1 || PIX_DIV > 16) begin : g_bad_div
            $error("vga_timing_gen: PIX_DIV must be in 1..16");
        end
        if (CNT_W < 1 || CNT_W > 30 ||
            ((H_TOTAL - 1) >> CNT_W) != 0 || ((V_TOTAL - 1) >> CNT_W) != 0) begin : g_bad_width
            $error("vga_timing_gen: CNT_W too narrow for H_TOTAL-1 / V_TOTAL-1");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] div_next;
    logic [CNT_W-1:0] col_reg;
    logic [CNT_W-1:0] col_next;
    logic [CNT_W-1:0] row_reg;
    logic [CNT_W-1:0] row_next;

    logic pix_tick;
    logic col_wrap;
    logic row_wrap;

    logic [31:0] col_wide;
    logic [31:0] row_wide;

    logic h_active_area;
    logic v_active_area;
    logic h_sync_window;
    logic v_sync_window;
    logic cmd_window;

    // Pixel divider: counts run-enabled clocks, ticks on its last value,
    // and simply holds whenever run is low.
    always_comb begin
        pix_tick = run && (div_reg == DIV_LAST);
        div_next = div_reg;
        if (run) begin
            if (div_reg == DIV_LAST) begin
                div_next = DIV_ZERO;
            end else begin
                div_next = div_reg + DIV_ONE;
            end
        end
    end

    // Raster counters: column advances per tick, row advances on column wrap.
    always_comb begin
        col_wrap = pix_tick && (col_reg == COL_LAST);
        row_wrap = col_wrap && (row_reg == ROW_LAST);

        col_next = col_reg;
        if (pix_tick) begin
            col_next = col_wrap ? CNT_ZERO : (col_reg + CNT_ONE);
        end

        row_next = row_reg;
        if (col_wrap) begin
            row_next = row_wrap ? CNT_ZERO : (row_reg + CNT_ONE);
        end
    end

    // Region decode on the next-state counters so registered flags line up
    // with the counter values they are loaded alongside.
    always_comb begin
        col_wide = 32'(col_next);
        row_wide = 32'(row_next);

        h_active_area = (col_wide < H_ACT_END);
        v_active_area = (row_wide < V_ACT_END);
        h_sync_window = (col_wide >= HS_START) && (col_wide < HS_END);
        v_sync_window = (row_wide >= VS_START) && (row_wide < VS_END);
        cmd_window    = (row_wide >= CMD_START) && (row_wide < CMD_END);
    end

    // Counter and divider registers; reset wins over run.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_reg <= DIV_ZERO;
            col_reg <= CNT_ZERO;
            row_reg <= CNT_ZERO;
        end else begin
            div_reg <= div_next;
            col_reg <= col_next;
            row_reg <= row_next;
        end
    end

    // Level outputs: reloaded from the next-state decode, which equals the
    // current decode while run is low, so they hold naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_sync          <= ~H_POL;
            v_sync          <= ~V_POL;
            screen_inactive <= 1'b0;
            cmd_en          <= 1'b0;
        end else begin
            h_sync          <= h_sync_window ? H_POL : ~H_POL;
            v_sync          <= v_sync_window ? V_POL : ~V_POL;
            screen_inactive <= ~(h_active_area && v_active_area);
            cmd_en          <= cmd_window;
        end
    end

    // Strobes: one clock wide, only after a tick that wrapped the column
    // (and the row, for frame_start). Wraps imply run, so run=0 gives 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= col_wrap;
            frame_start <= row_wrap;
        end
    end

    assign col_counter = col_reg;
    assign row_counter = row_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized scoreboard bench for vga_timing_gen.
// Three instances share clock, reset and run: the default 640x480 timing,
// a narrow-line variant with full 525-line vertical timing and PIX_DIV=2,
// and a tiny 14x7 frame with active-high syncs. The reference model derives
// every expected output from the number of run-enabled clocks since reset.
module tb_vga_timing_gen;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic [15:0] row;
        logic [15:0] col;
        logic        inact;
        logic        cmd;
        logic        ls;
        logic        fs;
    } obs_t;

    typedef struct {
        int ha, hf, hs, hb;
        int va, vf, vs, vb;
        bit hp, vp;
        int pd, cl;
    } cfg_t;

    localparam int NUM_CYC = 20000;
    localparam int RST_CYC = 18500;

    logic clk;
    logic rst_n;
    logic run;

    // Instance A: defaults
    logic       hs_a, vs_a, inact_a, cmd_a, ls_a, fs_a;
    logic [9:0] row_a, col_a;
    // Instance B: short lines, default vertical timing, PIX_DIV=2
    logic       hs_b, vs_b, inact_b, cmd_b, ls_b, fs_b;
    logic [9:0] row_b, col_b;
    // Instance C: 14x7 frame, active-high syncs
    logic       hs_c, vs_c, inact_c, cmd_c, ls_c, fs_c;
    logic [3:0] row_c, col_c;

    int checks = 0;
    int errors = 0;
    int mon_cyc = 0;

    obs_t q_a[$];
    obs_t q_b[$];
    obs_t q_c[$];

    vga_timing_gen dut_a (
        .clk(clk), .rst_n(rst_n), .run(run),
        .h_sync(hs_a), .v_sync(vs_a),
        .row_counter(row_a), .col_counter(col_a),
        .screen_inactive(inact_a), .cmd_en(cmd_a),
        .line_start(ls_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .CNT_W(10), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
        .H_POL(1'b0), .V_POL(1'b0), .PIX_DIV(2), .CMD_LINES(8)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .run(run),
        .h_sync(hs_b), .v_sync(vs_b),
        .row_counter(row_b), .col_counter(col_b),
        .screen_inactive(inact_b), .cmd_en(cmd_b),
        .line_start(ls_b), .frame_start(fs_b)
    );

    vga_timing_gen #(
        .CNT_W(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .V_POL(1'b1), .PIX_DIV(1), .CMD_LINES(2)
    ) dut_c (
        .clk(clk), .rst_n(rst_n), .run(run),
        .h_sync(hs_c), .v_sync(vs_c),
        .row_counter(row_c), .col_counter(col_c),
        .screen_inactive(inact_c), .cmd_en(cmd_c),
        .line_start(ls_c), .frame_start(fs_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: pixel ticks = run clocks / PIX_DIV; coordinates are that
    // tick count taken modulo the line and frame lengths.
    function automatic obs_t model(input cfg_t c, input longint runs, input bit ticked);
        obs_t   o;
        longint t, col, row, ht, vt;
        ht  = c.ha + c.hf + c.hs + c.hb;
        vt  = c.va + c.vf + c.vs + c.vb;
        t   = runs / c.pd;
        col = t % ht;
        row = (t / ht) % vt;
        o.col   = 16'(col);
        o.row   = 16'(row);
        o.hs    = (col >= c.ha + c.hf && col < c.ha + c.hf + c.hs) ? c.hp : ~c.hp;
        o.vs    = (row >= c.va + c.vf && row < c.va + c.vf + c.vs) ? c.vp : ~c.vp;
        o.inact = (col >= c.ha) || (row >= c.va);
        o.cmd   = (row >= c.va) && (row < c.va + c.cl);
        o.ls    = ticked && (col == 0);
        o.fs    = ticked && (col == 0) && (row == 0);
        return o;
    endfunction

    task automatic compare(input string name, input obs_t e, input obs_t a);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s cyc=%0d got hs=%b vs=%b row=%0d col=%0d inact=%b cmd=%b ls=%b fs=%b want hs=%b vs=%b row=%0d col=%0d inact=%b cmd=%b ls=%b fs=%b",
                     name, mon_cyc, a.hs, a.vs, a.row, a.col, a.inact, a.cmd, a.ls, a.fs,
                     e.hs, e.vs, e.row, e.col, e.inact, e.cmd, e.ls, e.fs);
        end
    endtask

    // Monitor: every clock each instance presents a new output set; pop the
    // matching expectation and compare.
    initial begin : monitor
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clk);
            #1;
            mon_cyc++;
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                a.hs = hs_a; a.vs = vs_a; a.row = 16'(row_a); a.col = 16'(col_a);
                a.inact = inact_a; a.cmd = cmd_a; a.ls = ls_a; a.fs = fs_a;
                compare("inst_a", e, a);
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                a.hs = hs_b; a.vs = vs_b; a.row = 16'(row_b); a.col = 16'(col_b);
                a.inact = inact_b; a.cmd = cmd_b; a.ls = ls_b; a.fs = fs_b;
                compare("inst_b", e, a);
            end
            if (q_c.size() > 0) begin
                e = q_c.pop_front();
                a.hs = hs_c; a.vs = vs_c; a.row = 16'(row_c); a.col = 16'(col_c);
                a.inact = inact_c; a.cmd = cmd_c; a.ls = ls_c; a.fs = fs_c;
                compare("inst_c", e, a);
            end
        end
    end

    // Stimulus: reset, then random run with occasional 5-clock holds, a
    // single-cycle mid-frame reset pulse, and more running afterwards.
    initial begin : stimulus
        cfg_t   cfg[3];
        longint runs[3];
        bit     ticked;
        obs_t   e;
        int     hold_left;
        int     frames_c;

        cfg[0] = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33,
                   hp:1'b0, vp:1'b0, pd:1, cl:8};
        cfg[1] = '{ha:8, hf:2, hs:2, hb:2, va:480, vf:10, vs:2, vb:33,
                   hp:1'b0, vp:1'b0, pd:2, cl:8};
        cfg[2] = '{ha:8, hf:2, hs:2, hb:2, va:4, vf:1, vs:1, vb:1,
                   hp:1'b1, vp:1'b1, pd:1, cl:2};
        for (int k = 0; k < 3; k++) runs[k] = 0;
        hold_left = 0;
        frames_c  = 0;
        rst_n = 1'b0;
        run   = 1'b0;
        $display("TXN reset: rst_n low for 3 cycles");

        for (int cyc = 0; cyc < NUM_CYC; cyc++) begin
            @(negedge clk);
            if (cyc < 3) begin
                rst_n = 1'b0;
                run   = 1'($urandom_range(0, 1));
            end else if (cyc == RST_CYC) begin
                rst_n = 1'b0;
                run   = 1'b1;
                $display("TXN mid-frame reset pulse at cycle %0d", cyc);
            end else begin
                rst_n = 1'b1;
                if (hold_left > 0) begin
                    run = 1'b0;
                    hold_left--;
                end else if ($urandom_range(0, 299) == 0) begin
                    run = 1'b0;
                    hold_left = 4;
                    $display("TXN run hold for 5 cycles at cycle %0d", cyc);
                end else begin
                    run = ($urandom_range(0, 99) < 92);
                end
            end

            for (int k = 0; k < 3; k++) begin
                if (!rst_n) begin
                    runs[k] = 0;
                    ticked  = 1'b0;
                end else if (run) begin
                    runs[k]++;
                    ticked = (runs[k] % cfg[k].pd) == 0;
                end else begin
                    ticked = 1'b0;
                end
                e = model(cfg[k], runs[k], ticked);
                if (k == 0) q_a.push_back(e);
                else if (k == 1) q_b.push_back(e);
                else begin
                    q_c.push_back(e);
                    if (e.fs) frames_c++;
                end
            end
        end

        repeat (3) @(negedge clk);
        $display("TXN done: %0d small-instance frames expected", frames_c);
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0 || q_c.size() != 0) begin
            errors++;
            $display("FAIL drain got pending=%0d/%0d/%0d want 0/0/0",
                     q_a.size(), q_b.size(), q_c.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
